// File: rtl/gdo_pkg.sv
// Shared fixed-point types and helpers for the gradient/weight datapath.
// Elements are signed data_size values; rows pack lane 0 in the most
// significant position.
package gdo_pkg;

    localparam int GDO_DATA_SIZE = 16;
    localparam int GDO_SIZE      = 3;

    typedef logic signed [GDO_DATA_SIZE-1:0]  elem_t;
    typedef logic signed [GDO_DATA_SIZE:0]    wide_t;
    typedef logic [GDO_DATA_SIZE*GDO_SIZE-1:0] row_t;
    typedef elem_t lanes_t [GDO_SIZE];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_READ
    } state_e;

    // Clamp a one-bit-wider sum back into the element range.
    function automatic elem_t gdo_clamp(input wide_t v);
        if (v[GDO_DATA_SIZE] != v[GDO_DATA_SIZE-1]) begin
            if (v[GDO_DATA_SIZE])
                return {1'b1, {(GDO_DATA_SIZE-1){1'b0}}};
            else
                return {1'b0, {(GDO_DATA_SIZE-1){1'b1}}};
        end
        return v[GDO_DATA_SIZE-1:0];
    endfunction

    // a + b with saturation.
    function automatic elem_t gdo_sat_add(input elem_t a, input elem_t b);
        wide_t s;
        s = wide_t'(a) + wide_t'(b);
        return gdo_clamp(s);
    endfunction

    // w - (g >>> sh) with saturation; the shift floors toward -infinity.
    function automatic elem_t gdo_shift_sub(input elem_t w, input elem_t g, input int unsigned sh);
        elem_t gs;
        wide_t d;
        gs = g >>> sh;
        d  = wide_t'(w) - wide_t'(gs);
        return gdo_clamp(d);
    endfunction

    // Extract lane j of a packed row (lane 0 is the top slice).
    function automatic elem_t gdo_lane(input row_t r, input int j);
        elem_t e;
        e = '0;
        for (int k = 0; k < GDO_SIZE; k++) begin
            if (k == j)
                e = r[(GDO_SIZE-k)*GDO_DATA_SIZE-1 -: GDO_DATA_SIZE];
        end
        return e;
    endfunction

    // Pack lanes into a row, lane 0 in the top slice.
    function automatic row_t gdo_pack_row(input lanes_t lanes);
        row_t r;
        r = '0;
        for (int k = 0; k < GDO_SIZE; k++)
            r[(GDO_SIZE-k)*GDO_DATA_SIZE-1 -: GDO_DATA_SIZE] = lanes[k];
        return r;
    endfunction

endpackage

// File: rtl/weight_row_lane.sv
// One column of the update datapath: saturating gradient accumulate for
// the row currently being filled, and the SGD step for every row of the
// layer being applied.
module weight_row_lane
    import gdo_pkg::*;
#(
    parameter int ROWS     = 3,
    parameter int LR_SHIFT = 4
) (
    input  elem_t acc_grad_i,
    input  elem_t acc_beat_i,
    output elem_t acc_grad_o,
    input  elem_t apply_weight_i [ROWS],
    input  elem_t apply_grad_i   [ROWS],
    output elem_t apply_weight_o [ROWS]
);

    assign acc_grad_o = gdo_sat_add(acc_grad_i, acc_beat_i);

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            assign apply_weight_o[gi] = gdo_shift_sub(apply_weight_i[gi], apply_grad_i[gi], LR_SHIFT);
        end
    endgenerate

endmodule

// File: rtl/weight_update_stack.sv
// Weight/gradient store for all layers. Accumulates gradient rows from the
// backprop stream, applies SGD to every layer on batch_end (one layer per
// cycle), streams weight rows out on request and accepts direct row writes.
module weight_update_stack
    import gdo_pkg::*;
#(
    parameter int data_size      = GDO_DATA_SIZE,
    parameter int size           = GDO_SIZE,
    parameter int max_layer_size = 4,
    parameter int lr_shift       = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [data_size*size-1:0]   dc_dw_stream,
    input  logic                        dc_dw_valid,
    input  logic [31:0]                 dc_dw_layer_index,
    input  logic                        batch_end,
    input  logic                        read_req,
    input  logic [31:0]                 read_layer_index,
    input  logic                        wr_en,
    input  logic [31:0]                 wr_layer,
    input  logic [31:0]                 wr_row,
    input  logic [data_size*size-1:0]   wr_data,
    output logic                        ready,
    output logic [data_size*size-1:0]   weight_stream,
    output logic                        weight_valid,
    output logic [31:0]                 weight_row,
    output logic                        drop_err
);

    localparam int LW = (max_layer_size > 1) ? $clog2(max_layer_size) : 1;
    // Row counters also need to hold the value "size" for the read-out end test.
    localparam int RW = $clog2(size + 1);

    // Storage
    elem_t weight_q [max_layer_size][size][size];
    elem_t grad_q   [max_layer_size][size][size];
    logic [RW-1:0] row_cnt_q [max_layer_size];

    // Control and registered outputs
    state_e        state_q;
    logic [LW-1:0] lc_q;
    logic [RW-1:0] rc_q;
    logic [LW-1:0] rl_q;
    logic [data_size*size-1:0] weight_stream_q;
    logic          weight_valid_q;
    logic [31:0]   weight_row_q;
    logic          drop_err_q;

    // Datapath next values
    logic [LW-1:0] acc_layer_d;
    logic [RW-1:0] acc_row_d;
    elem_t         beat_lane_d   [size];
    elem_t         grad_acc_d    [size];
    elem_t         weight_apply_d[size][size];
    logic [LW-1:0] rd_layer_d;
    logic [RW-1:0] rd_row_d;
    lanes_t        read_lanes_d;
    row_t          read_row_d;
    logic          acc_ok_d;
    logic          wr_ok_d;
    logic          rd_ok_d;

    assign acc_ok_d = dc_dw_layer_index < 32'(max_layer_size);
    assign wr_ok_d  = (wr_layer < 32'(max_layer_size)) && (wr_row < 32'(size));
    assign rd_ok_d  = read_layer_index < 32'(max_layer_size);

    assign acc_layer_d = dc_dw_layer_index[LW-1:0];
    assign acc_row_d   = row_cnt_q[acc_layer_d];

    // The first read-out row is taken straight from the request; later rows from the latched layer.
    assign rd_layer_d = (state_q == ST_IDLE) ? read_layer_index[LW-1:0] : rl_q;
    assign rd_row_d   = (state_q == ST_IDLE) ? '0 : rc_q;
    assign read_row_d = gdo_pack_row(read_lanes_d);

    generate
        for (genvar gi = 0; gi < size; gi++) begin : g_lane
            elem_t col_weight [size];
            elem_t col_grad   [size];
            elem_t col_new    [size];

            assign beat_lane_d[gi]  = gdo_lane(dc_dw_stream, gi);
            assign read_lanes_d[gi] = weight_q[rd_layer_d][rd_row_d][gi];

            for (genvar gr = 0; gr < size; gr++) begin : g_col
                assign col_weight[gr]         = weight_q[lc_q][gr][gi];
                assign col_grad[gr]           = grad_q[lc_q][gr][gi];
                assign weight_apply_d[gr][gi] = col_new[gr];
            end

            weight_row_lane #(
                .ROWS     (size),
                .LR_SHIFT (lr_shift)
            ) u_lane (
                .acc_grad_i     (grad_q[acc_layer_d][acc_row_d][gi]),
                .acc_beat_i     (beat_lane_d[gi]),
                .acc_grad_o     (grad_acc_d[gi]),
                .apply_weight_i (col_weight),
                .apply_grad_i   (col_grad),
                .apply_weight_o (col_new)
            );
        end
    endgenerate

    // Control FSM, storage updates and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            lc_q            <= '0;
            rc_q            <= '0;
            rl_q            <= '0;
            weight_stream_q <= '0;
            weight_valid_q  <= 1'b0;
            weight_row_q    <= '0;
            drop_err_q      <= 1'b0;
            for (int l = 0; l < max_layer_size; l++) begin
                row_cnt_q[l] <= '0;
                for (int r = 0; r < size; r++) begin
                    for (int j = 0; j < size; j++) begin
                        weight_q[l][r][j] <= '0;
                        grad_q[l][r][j]   <= '0;
                    end
                end
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (batch_end) begin
                        state_q <= ST_APPLY;
                        lc_q    <= '0;
                        if (dc_dw_valid || wr_en)
                            drop_err_q <= 1'b1;
                    end else if (read_req) begin
                        if (rd_ok_d) begin
                            state_q         <= ST_READ;
                            rl_q            <= read_layer_index[LW-1:0];
                            weight_stream_q <= read_row_d;
                            weight_valid_q  <= 1'b1;
                            weight_row_q    <= '0;
                            rc_q            <= RW'(1);
                        end else begin
                            drop_err_q <= 1'b1;
                        end
                        if (dc_dw_valid || wr_en)
                            drop_err_q <= 1'b1;
                    end else if (wr_en) begin
                        if (wr_ok_d) begin
                            for (int j = 0; j < size; j++)
                                weight_q[wr_layer[LW-1:0]][wr_row[RW-1:0]][j] <= gdo_lane(wr_data, j);
                        end else begin
                            drop_err_q <= 1'b1;
                        end
                        if (dc_dw_valid)
                            drop_err_q <= 1'b1;
                    end else if (dc_dw_valid) begin
                        if (acc_ok_d) begin
                            for (int j = 0; j < size; j++)
                                grad_q[acc_layer_d][acc_row_d][j] <= grad_acc_d[j];
                            row_cnt_q[acc_layer_d] <= (acc_row_d == RW'(size - 1)) ? '0 : acc_row_d + RW'(1);
                        end else begin
                            drop_err_q <= 1'b1;
                        end
                    end
                end

                ST_APPLY: begin
                    for (int r = 0; r < size; r++) begin
                        for (int j = 0; j < size; j++) begin
                            weight_q[lc_q][r][j] <= weight_apply_d[r][j];
                            grad_q[lc_q][r][j]   <= '0;
                        end
                    end
                    row_cnt_q[lc_q] <= '0;
                    if (lc_q == LW'(max_layer_size - 1))
                        state_q <= ST_IDLE;
                    else
                        lc_q <= lc_q + LW'(1);
                    if (dc_dw_valid || wr_en)
                        drop_err_q <= 1'b1;
                end

                ST_READ: begin
                    if (rc_q == RW'(size)) begin
                        weight_valid_q <= 1'b0;
                        state_q        <= ST_IDLE;
                    end else begin
                        weight_stream_q <= read_row_d;
                        weight_row_q    <= 32'(rc_q);
                        rc_q            <= rc_q + RW'(1);
                    end
                    if (dc_dw_valid || wr_en)
                        drop_err_q <= 1'b1;
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ready         = (state_q == ST_IDLE);
    assign weight_stream = weight_stream_q;
    assign weight_valid  = weight_valid_q;
    assign weight_row    = weight_row_q;
    assign drop_err      = drop_err_q;

endmodule

// File: tb/tb_weight_update_stack.sv
// Directed bench for weight_update_stack: write, accumulate, apply and
// read-out sequences with hand-computed expected rows.
module tb_weight_update_stack;

    logic        clk;
    logic        reset;
    logic [47:0] dc_dw_stream;
    logic        dc_dw_valid;
    logic [31:0] dc_dw_layer_index;
    logic        batch_end;
    logic        read_req;
    logic [31:0] read_layer_index;
    logic        wr_en;
    logic [31:0] wr_layer;
    logic [31:0] wr_row;
    logic [47:0] wr_data;
    logic        ready;
    logic [47:0] weight_stream;
    logic        weight_valid;
    logic [31:0] weight_row;
    logic        drop_err;

    int tests_run    = 0;
    int tests_failed = 0;

    weight_update_stack dut (
        .clk               (clk),
        .reset             (reset),
        .dc_dw_stream      (dc_dw_stream),
        .dc_dw_valid       (dc_dw_valid),
        .dc_dw_layer_index (dc_dw_layer_index),
        .batch_end         (batch_end),
        .read_req          (read_req),
        .read_layer_index  (read_layer_index),
        .wr_en             (wr_en),
        .wr_layer          (wr_layer),
        .wr_row            (wr_row),
        .wr_data           (wr_data),
        .ready             (ready),
        .weight_stream     (weight_stream),
        .weight_valid      (weight_valid),
        .weight_row        (weight_row),
        .drop_err          (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] pk(input int a, input int b, input int c);
        return {16'(a), 16'(b), 16'(c)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_row(input int layer, input int row, input logic [47:0] data);
        wr_en = 1'b1; wr_layer = layer; wr_row = row; wr_data = data;
        tick();
        wr_en = 1'b0;
        $display("[TB] write layer %0d row %0d data %h", layer, row, data);
    endtask

    task automatic send_beats(input int layer, input logic [47:0] data, input int n);
        dc_dw_valid = 1'b1; dc_dw_layer_index = layer; dc_dw_stream = data;
        for (int i = 0; i < n; i++) tick();
        dc_dw_valid = 1'b0;
        $display("[TB] %0d beat(s) layer %0d data %h", n, layer, data);
    endtask

    // batch_end pulse; whatever else is driven alongside is removed after the first edge.
    task automatic run_batch();
        batch_end = 1'b1;
        tick();
        batch_end = 1'b0; dc_dw_valid = 1'b0; read_req = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("apply_busy", 64'(ready), 64'(0));
            check("apply_no_rd", 64'(weight_valid), 64'(0));
            tick();
        end
        check("apply_done", 64'(ready), 64'(1));
        $display("[TB] batch applied");
    endtask

    task automatic read_layer(input int layer, input logic [47:0] r0, input logic [47:0] r1, input logic [47:0] r2);
        logic [47:0] exp_rows [3];
        exp_rows[0] = r0; exp_rows[1] = r1; exp_rows[2] = r2;
        read_req = 1'b1; read_layer_index = layer;
        tick();
        read_req = 1'b0;
        for (int r = 0; r < 3; r++) begin
            check("rd_valid", 64'(weight_valid), 64'(1));
            check("rd_busy", 64'(ready), 64'(0));
            check("rd_row", 64'(weight_row), 64'(r));
            check("rd_data", 64'(weight_stream), 64'(exp_rows[r]));
            $display("[TB] read layer %0d row %0d data %h", layer, weight_row, weight_stream);
            tick();
        end
        check("rd_end_valid", 64'(weight_valid), 64'(0));
        check("rd_end_ready", 64'(ready), 64'(1));
    endtask

    initial begin
        reset = 1'b1;
        dc_dw_stream = '0; dc_dw_valid = 1'b0; dc_dw_layer_index = '0;
        batch_end = 1'b0; read_req = 1'b0; read_layer_index = '0;
        wr_en = 1'b0; wr_layer = '0; wr_row = '0; wr_data = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_ready", 64'(ready), 64'(1));
        check("rst_valid", 64'(weight_valid), 64'(0));
        check("rst_row", 64'(weight_row), 64'(0));
        check("rst_stream", 64'(weight_stream), 64'(0));
        check("rst_drop", 64'(drop_err), 64'(0));
        read_layer(0, pk(0, 0, 0), pk(0, 0, 0), pk(0, 0, 0));

        // Basic write / accumulate / apply
        write_row(1, 0, pk(100, 200, 300));
        send_beats(1, pk(64, -64, 16), 2);
        run_batch();
        read_layer(1, pk(96, 204, 299), pk(-4, 4, -1), pk(0, 0, 0));

        // Saturation of gradient accumulate and of the weight update
        write_row(0, 0, pk(32767, 0, -32760));
        send_beats(0, pk(-32768, -32768, 20000), 4);
        run_batch();
        read_layer(0, pk(32767, 2048, -32768), pk(2048, 2048, -1250), pk(2048, 2048, -1250));
        check("no_drop_yet", 64'(drop_err), 64'(0));

        // Out-of-range beat, then a beat during APPLY
        send_beats(4, pk(5, 5, 5), 1);
        check("drop_oor", 64'(drop_err), 64'(1));
        batch_end = 1'b1;
        tick();
        batch_end = 1'b0;
        send_beats(3, pk(160, 0, 0), 1);
        check("apply_drop_busy", 64'(ready), 64'(0));
        tick(); tick(); tick();
        check("apply_drop_done", 64'(ready), 64'(1));
        send_beats(3, pk(320, 0, 0), 1);
        run_batch();
        read_layer(3, pk(-20, 0, 0), pk(0, 0, 0), pk(0, 0, 0));

        // batch_end with a beat in the same cycle; floor-rounding of the shift
        send_beats(2, pk(-1, -17, 31), 1);
        dc_dw_valid = 1'b1; dc_dw_layer_index = 2; dc_dw_stream = pk(1000, 1000, 1000);
        run_batch();
        read_layer(2, pk(1, 2, -1), pk(0, 0, 0), pk(0, 0, 0));

        // batch_end with read_req: only APPLY runs
        read_req = 1'b1; read_layer_index = 0;
        run_batch();
        tick();
        check("batch_rd_ignored", 64'(weight_valid), 64'(0));
        read_layer(0, pk(32767, 2048, -32768), pk(2048, 2048, -1250), pk(2048, 2048, -1250));

        // Reset on the second cycle of READ
        read_req = 1'b1; read_layer_index = 1;
        tick();
        read_req = 1'b0;
        check("pre_rst_valid", 64'(weight_valid), 64'(1));
        check("pre_rst_data", 64'(weight_stream), 64'(pk(96, 204, 299)));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", 64'(weight_valid), 64'(0));
        check("mid_rst_ready", 64'(ready), 64'(1));
        check("mid_rst_row", 64'(weight_row), 64'(0));
        check("mid_rst_drop", 64'(drop_err), 64'(0));
        $display("[TB] reset during read");
        read_layer(1, pk(0, 0, 0), pk(0, 0, 0), pk(0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/weight_update_stack.md
Name: weight_update_stack

Overview:
- Consumer end of the `dc_dw_stream` produced by the backprop stage.
- Accumulates per-layer weight gradients, one matrix row per accepted beat.
- On `batch_end`, applies SGD to all layers: w <= w - (grad >>> lr_shift), then clears the gradients.
- Serves a row-per-cycle weight read-out stream back to the forward/dense datapath, and accepts direct weight writes for initial load.

Parameters:
- data_size, 16: bit width of one signed fixed-point element (gdo format).
- size, 3: elements per row; each layer matrix is size x size.
- max_layer_size, 4: number of layers stored.
- lr_shift, 4: learning rate as 2^-lr_shift; arithmetic right shift of the accumulated gradient.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- dc_dw_stream  in  data_size*size  gradient row; element j at bits [(size-j)*data_size-1 -: data_size].
- dc_dw_valid  in  1  gradient beat valid.
- dc_dw_layer_index  in  32  target layer of the beat.
- batch_end  in  1  one-cycle pulse that requests the apply pass.
- read_req  in  1  one-cycle pulse that requests a read-out of read_layer_index.
- read_layer_index  in  32  layer to stream out.
- wr_en  in  1  direct weight row write.
- wr_layer  in  32  layer for the direct write.
- wr_row  in  32  row for the direct write.
- wr_data  in  data_size*size  row data, same packing as dc_dw_stream.
- ready  out  1  high only in IDLE; beats, writes and requests are accepted only when ready=1.
- weight_stream  out  data_size*size  weight row, same packing.
- weight_valid  out  1  weight_stream holds a valid row.
- weight_row  out  32  row index of the current weight_stream beat.
- drop_err  out  1  sticky; set when a beat or write is discarded.

Behaviour:
- Reset (synchronous, active-high; overrides everything, including mid-APPLY and mid-READ):
  - state=IDLE.
  - weight[][][], grad[][][] and row_cnt[] all cleared to 0.
  - weight_stream=0, weight_valid=0, weight_row=0, drop_err=0, ready=1 on the next cycle.
- State IDLE. Priority when several inputs are high in the same cycle: batch_end > read_req > wr_en > dc_dw_valid.
  - batch_end -> APPLY with layer counter lc=0. A beat presented in the same cycle is dropped and sets drop_err.
  - read_req with read_layer_index < max_layer_size -> READ with rc=0. An out-of-range index sets drop_err and the block stays in IDLE.
  - wr_en with wr_layer and wr_row in range -> weight[wr_layer][wr_row][j] <= wr_data lane j. Out of range: ignored, drop_err set.
  - dc_dw_valid with L=dc_dw_layer_index < max_layer_size:
    - grad[L][row_cnt[L]][j] <= sat(grad + lane j).
    - row_cnt[L] increments and wraps from size-1 to 0.
  - dc_dw_valid with L out of range: beat dropped, drop_err set, no counter change.
- State APPLY (one layer per cycle, max_layer_size cycles, ready=0):
  - For every row r and column j: weight[lc][r][j] <= sat(weight - (grad >>> lr_shift)). The shift is arithmetic and rounds toward -infinity.
  - grad[lc] cleared to 0; row_cnt[lc] cleared to 0.
  - lc == max_layer_size-1 -> IDLE.
  - Any beat arriving in APPLY is dropped and sets drop_err.
- State READ (size cycles, ready=0):
  - Registered output: the cycle after entry, weight_valid=1 with weight_row=rc and weight_stream = row rc of the selected layer.
  - rc advances each cycle. After the row size-1 beat: weight_valid=0, state -> IDLE.
  - Read-out is a snapshot: no writes are possible during READ.
- Arithmetic: all element values are signed data_size. sat() clamps to [-2^(data_size-1), 2^(data_size-1)-1]. Internal sums use data_size+1 bits before the clamp.
- Latencies:
  - Accumulate: 1 cycle.
  - Apply: max_layer_size cycles.
  - Read: first row 1 cycle after read_req, last row size cycles after read_req, back in IDLE on the following cycle.
- A partial row set (row_cnt != 0) at batch_end is still applied; row_cnt is cleared regardless.

Decomposition:
- gdo package (extend the existing one):
  - `gdo_sat_add`, add with clamp.
  - `gdo_shift_sub`, weight minus shifted gradient with clamp.
  - a typedef for the signed data_size element.
  - functions for row pack/unpack using the MSB-first lane order.
- One natural sub-module: `weight_row_lane`, the per-element accumulate/apply datapath, instantiated size times by generate. FSM and storage stay in the top.

Test Plan:
- Reset, then read_req layer 0 -> weight_valid for exactly 3 cycles, rows 0..2, all lanes 0, ready=1 afterwards.
- wr_en layer 1 row 0 with {100,200,300}; two beats of {64,-64,16} to layer 1, rows 0 then 1; batch_end; read layer 1 -> row0 = {96,204,299}, row1 = {-4,4,-1}, row2 = {0,0,0}.
- Saturation: write 32767 to layer 0 row 0 lane 0, accumulate -32768 twice, batch_end -> lane 0 stays 32767, grad clamped to -32768 with no wrap.
- Boundary drops: beat with dc_dw_layer_index=4, then dc_dw_valid asserted during APPLY -> both beats dropped, drop_err=1, row_cnt unchanged.
- Simultaneous inputs: batch_end and dc_dw_valid in the same cycle -> the beat is dropped and APPLY runs; batch_end and read_req together -> APPLY only, read ignored.
- Reset asserted on the second cycle of READ -> weight_valid=0 on the next cycle, state IDLE, weights read back as 0.
